// File: rtl/lcd_timing_driver.sv
// 640x480@60 VGA timing generator: issues pixel coordinates DATA_LAT cycles early, drives registered sync/DE/RGB.
// Optional build macro LCD_TEST_PATTERN_EN replaces lcd_data with eight vertical colour bars.
module lcd_timing_driver #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int DATA_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lcd_data,
  output logic        lcd_request,
  output logic [10:0] lcd_xpos,
  output logic [10:0] lcd_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        lcd_frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
  localparam logic [10:0] VT_M1 = 11'(V_TOTAL - 1);
  localparam logic [10:0] HSY   = 11'(H_SYNC);
  localparam logic [10:0] VSY   = 11'(V_SYNC);
  localparam logic [10:0] HS    = 11'(H_START);
  localparam logic [10:0] HE    = 11'(H_START + H_DISP);
  localparam logic [10:0] VS    = 11'(V_START);
  localparam logic [10:0] VE    = 11'(V_START + V_DISP);
  localparam logic [10:0] HRS   = 11'(H_START - DATA_LAT);
  localparam logic [10:0] HRE   = 11'(H_START - DATA_LAT + H_DISP);

  logic [10:0] h_cnt, v_cnt;
  logic        v_in, vis, req;
  logic [15:0] pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HT_M1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VT_M1) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign v_in = (v_cnt >= VS) && (v_cnt < VE);
  assign vis  = v_in && (h_cnt >= HS) && (h_cnt < HE);
  // Request window leads the visible window by DATA_LAT so the returned pixel lands exactly on it.
  assign req  = v_in && (h_cnt >= HRS) && (h_cnt < HRE);

  assign lcd_request = req && !rst;
  assign lcd_xpos    = lcd_request ? h_cnt - HRS : '0;
  assign lcd_ypos    = lcd_request ? v_cnt - VS  : '0;

`ifdef LCD_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_DISP / 8);
  logic [10:0] col, bar;
  logic        unused_data;
  assign unused_data = ^lcd_data;
  assign col = h_cnt - HS;
  assign bar = col / BAR_W;
  always_comb begin
    pix = 16'h07FF;
    case (bar)
      11'd0: pix = 16'hF800;
      11'd1: pix = 16'h07E0;
      11'd2: pix = 16'h001F;
      11'd3: pix = 16'hFFFF;
      11'd4: pix = 16'h0000;
      11'd5: pix = 16'hFFE0;
      11'd6: pix = 16'hF81F;
      default: pix = 16'h07FF;
    endcase
  end
`else
  assign pix = lcd_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_hs          <= 1'b1;
      lcd_vs          <= 1'b1;
      lcd_de          <= 1'b0;
      lcd_rgb         <= '0;
      lcd_frame_start <= 1'b0;
    end else begin
      lcd_hs          <= (h_cnt >= HSY);
      lcd_vs          <= (v_cnt >= VSY);
      lcd_de          <= vis;
      lcd_rgb         <= vis ? pix : '0;
      lcd_frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver on a reduced raster (25x13 clocks, 16x6 visible, DATA_LAT=2).
// Build with LCD_TEST_PATTERN_EN defined to check the colour-bar variant instead of pass-through.
module tb_lcd_timing_driver;
  // Small raster: H_START=7, H_TOTAL=25, V_START=5, V_TOTAL=13, frame=325 clocks.
  localparam int HSW = 4, HBP = 3, HDP = 16, HFP = 2;
  localparam int VSW = 2, VBP = 3, VDP = 6,  VFP = 2;
  localparam int LAT = 2;
  localparam int FRAME = 325;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] lcd_data;
  logic        lcd_request, lcd_hs, lcd_vs, lcd_de, lcd_frame_start;
  logic [10:0] lcd_xpos, lcd_ypos;
  logic [15:0] lcd_rgb;
  logic [15:0] d1 = '0, d2 = '0;

  int n_chk = 0, n_fail = 0;

  lcd_timing_driver #(
    .H_SYNC(HSW), .H_BACK(HBP), .H_DISP(HDP), .H_FRONT(HFP),
    .V_SYNC(VSW), .V_BACK(VBP), .V_DISP(VDP), .V_FRONT(VFP), .DATA_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_request(lcd_request),
    .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
    .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .lcd_frame_start(lcd_frame_start)
  );

  always #5 clk = ~clk;

  // Pixel source: returns {ypos[4:0], xpos} two clocks after the request.
  always @(posedge clk) begin
    d1 <= lcd_request ? {lcd_ypos[4:0], lcd_xpos} : 16'h0000;
    d2 <= d1;
  end
`ifdef LCD_TEST_PATTERN_EN
  assign lcd_data = 16'hAAAA;
`else
  assign lcd_data = d2;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_hs"}, 32'(lcd_hs), 32'd1);
    chk({tag, "_vs"}, 32'(lcd_vs), 32'd1);
    chk({tag, "_de"}, 32'(lcd_de), 32'd0);
    chk({tag, "_rgb"}, 32'(lcd_rgb), 32'd0);
    chk({tag, "_fs"}, 32'(lcd_frame_start), 32'd0);
    chk({tag, "_req"}, 32'(lcd_request), 32'd0);
    chk({tag, "_xpos"}, 32'(lcd_xpos), 32'd0);
    chk({tag, "_ypos"}, 32'(lcd_ypos), 32'd0);
  endtask

  function automatic logic [15:0] exp_pix(input int row, input int col);
`ifdef LCD_TEST_PATTERN_EN
    case (col / 2)
      0: return 16'hF800;
      1: return 16'h07E0;
      2: return 16'h001F;
      3: return 16'hFFFF;
      4: return 16'h0000;
      5: return 16'hFFE0;
      6: return 16'hF81F;
      default: return 16'h07FF;
    endcase
`else
    return {5'(row), 11'(col)};
`endif
  endfunction

  initial begin
    logic prev_hs, prev_de;
    int last_fall, rise_cyc, falls, bursts0, row, col, vs_low0, fs_cnt, last_fs;
    bit first_burst, found;

    // Reset held for 5 cycles; all outputs at reset values throughout.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_rst("rst_hold");
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_fs", 32'(lcd_frame_start), 32'd1);
    chk("rel_hs", 32'(lcd_hs), 32'd0);
    chk("rel_vs", 32'(lcd_vs), 32'd0);
    chk("rel_de", 32'(lcd_de), 32'd0);

    // Two full frames of line/frame/pixel measurements; cycle 1 is the sample above.
    prev_hs = 1'b1; prev_de = 1'b0;
    last_fall = 0; rise_cyc = 0; falls = 0; bursts0 = 0; row = 0; col = 0;
    vs_low0 = 0; fs_cnt = 0; last_fs = 0; first_burst = 1'b1;
    for (int cyc = 1; cyc <= 2 * FRAME; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (lcd_frame_start) begin
        if (fs_cnt > 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        fs_cnt++; last_fs = cyc; row = 0;
      end
      if (prev_hs && !lcd_hs) begin
        if (falls > 0) chk("hs_period", 32'(cyc - last_fall), 32'd25);
        last_fall = cyc; falls++;
      end
      if (!prev_hs && lcd_hs) chk("hs_low", 32'(cyc - last_fall), 32'(HSW));
      if (cyc <= FRAME && !lcd_vs) vs_low0++;
      if (!prev_de && lcd_de) begin
        chk("de_offset", 32'(cyc - last_fall), 32'd7);
        if (first_burst) chk("first_line", 32'(falls - 1), 32'd5);
        first_burst = 1'b0;
        if (cyc <= FRAME) bursts0++;
        rise_cyc = cyc; col = 0;
      end
      if (prev_de && !lcd_de) begin
        chk("de_width", 32'(cyc - rise_cyc), 32'(HDP));
        row++;
      end
      if (lcd_de) begin
        chk("pix", 32'(lcd_rgb), 32'(exp_pix(row, col)));
`ifdef LCD_TEST_PATTERN_EN
        if (lcd_rgb == 16'hAAAA) chk("no_aaaa", 32'(lcd_rgb), 32'h0);
`else
        if (row == 0 && col == 0) chk("first_pix", 32'(lcd_rgb), 32'h0000);
        if (row == VDP - 1 && col == HDP - 1) chk("last_pix", 32'(lcd_rgb), 32'h280F);
`endif
        col++;
      end else begin
        chk("blank_rgb", 32'(lcd_rgb), 32'd0);
      end
      prev_hs = lcd_hs; prev_de = lcd_de;
    end
    chk("fs_count", 32'(fs_cnt), 32'd2);
    chk("vs_low", 32'(vs_low0), 32'd50);
    chk("bursts", 32'(bursts0), 32'(VDP));

    // Mid-frame reset while a visible line is in progress.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (lcd_de) found = 1'b1;
    end
    chk("pre_rst_found", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    chk("pre_rst_de", 32'(lcd_de), 32'd1);
    rst = 1'b1;
    #1;
    chk_rst("mid_rst");
    repeat (3) @(negedge clk);
    chk_rst("mid_hold");
    rst = 1'b0;
    @(negedge clk);
    chk("rel2_fs", 32'(lcd_frame_start), 32'd1);
    falls = 1; prev_hs = lcd_hs; found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (prev_hs && !lcd_hs) falls++;
      if (lcd_de) found = 1'b1;
      prev_hs = lcd_hs;
    end
    chk("rel2_de_seen", 32'(found), 32'd1);
    chk("rel2_line", 32'(falls - 1), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
